// File: rtl/coil_pkg.sv
// coil_pkg: shared types for the scan-loop coil driver.
// State encoding and the amplitude/PWM width used up and downstream.
package coil_pkg;

    localparam int PWM_BITS = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DEAD  = 3'd1,
        ST_POS   = 3'd2,
        ST_NEG   = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    function automatic logic is_drive(input state_t s);
        return (s == ST_POS) || (s == ST_NEG);
    endfunction

endpackage

// File: rtl/coil_pwm.sv
// coil_pwm: free-running PWM phase counter with synchronous clear.
// Reports whether the high-side switch is on in the coming cycle.
module coil_pwm
    import coil_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [PWM_BITS-1:0] amp,
    output logic                pwm_on
);

    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] cnt_next;

    // Advance the phase, wrapping naturally at 2^PWM_BITS, or restart it.
    always_comb begin
        cnt_next = cnt + 1'b1;
        if (clr) begin
            cnt_next = '0;
        end
    end

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    // Looking at the next phase lets the gate register stay aligned with it.
    assign pwm_on = (cnt_next < amp);

endmodule

// File: rtl/coil_driver.sv
// coil_driver: H-bridge gate control for the scan loop.
// Dead-time on every drive entry, PWM duty from a latched amplitude, on-time watchdog.
module coil_driver
    import coil_pkg::*;
#(
    parameter int DEAD_CYCLES   = 8,
    parameter int MAX_ON_CYCLES = 50000
) (
    input  logic                CLK_IN,
    input  logic                rst_n,
    input  logic                scan_en,
    input  logic                pol_req,
    input  logic [PWM_BITS-1:0] amp_code,
    input  logic                cfg_valid,
    input  logic                fault_clr,
    output logic                HB_AH,
    output logic                HB_AL,
    output logic                HB_BH,
    output logic                HB_BL,
    output logic [2:0]          drv_state,
    output logic                fault
);

    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam int OW = $clog2(MAX_ON_CYCLES + 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
    localparam logic [OW-1:0] ON_LAST   = OW'(MAX_ON_CYCLES - 1);

    state_t              state;
    state_t              state_next;
    logic                target;
    logic                target_next;
    logic [PWM_BITS-1:0] amp_reg;
    logic [DW-1:0]       dead_cnt;
    logic [DW-1:0]       dead_next;
    logic [OW-1:0]       on_cnt;
    logic [OW-1:0]       on_next;
    logic                stay_drive;
    logic                pwm_on;
    logic [3:0]          gates;
    logic [3:0]          gates_next;

    coil_pwm u_pwm (
        .clk    (CLK_IN),
        .rst_n  (rst_n),
        .clr    (!stay_drive),
        .amp    (amp_reg),
        .pwm_on (pwm_on)
    );

    // Next-state decision; watchdog outranks turn-off, which outranks a polarity flip.
    always_comb begin
        state_next  = state;
        target_next = target;
        unique case (state)
            ST_IDLE: begin
                if (scan_en && (amp_reg != '0)) begin
                    state_next  = ST_DEAD;
                    target_next = pol_req;
                end
            end
            ST_DEAD: begin
                if (!scan_en) begin
                    state_next = ST_IDLE;
                end else if (dead_cnt == DEAD_LAST) begin
                    state_next = target ? ST_POS : ST_NEG;
                end
            end
            ST_POS, ST_NEG: begin
                if (on_cnt == ON_LAST) begin
                    state_next = ST_FAULT;
                end else if (!scan_en) begin
                    state_next = ST_IDLE;
                end else if (pol_req != (state == ST_POS)) begin
                    state_next  = ST_DEAD;
                    target_next = pol_req;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Counter updates and gate pattern for the state being entered.
    always_comb begin
        stay_drive = is_drive(state) && (state_next == state);
        dead_next  = '0;
        on_next    = '0;
        gates_next = 4'b0000;
        if ((state == ST_DEAD) && (state_next == ST_DEAD)) begin
            dead_next = dead_cnt + DW'(1);
        end
        if (stay_drive) begin
            on_next = on_cnt + OW'(1);
        end
        if (state_next == ST_POS) begin
            gates_next = {pwm_on, 1'b0, 1'b0, 1'b1};
        end else if (state_next == ST_NEG) begin
            gates_next = {1'b0, 1'b1, pwm_on, 1'b0};
        end
    end

    // State, counters and registered gate outputs; reset drops gates at once.
    always_ff @(posedge CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            target   <= 1'b0;
            dead_cnt <= '0;
            on_cnt   <= '0;
            gates    <= 4'b0000;
            fault    <= 1'b0;
        end else begin
            state    <= state_next;
            target   <= target_next;
            dead_cnt <= dead_next;
            on_cnt   <= on_next;
            gates    <= gates_next;
            fault    <= (state_next == ST_FAULT);
        end
    end

    // Amplitude is only accepted while idle.
    always_ff @(posedge CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            amp_reg <= '0;
        end else if ((state == ST_IDLE) && cfg_valid) begin
            amp_reg <= amp_code;
        end
    end

    assign {HB_AH, HB_AL, HB_BH, HB_BL} = gates;
    assign drv_state = state;

endmodule

// File: tb/tb_coil_driver.sv
// tb_coil_driver: scenario and randomized checks of coil_driver.
// Expectations come from a time-in-state behavioural model.
module tb_coil_driver;

    localparam int DEAD = 4;
    localparam int MAXON = 64;
    localparam int M_IDLE = 0, M_DEAD = 1, M_POS = 2, M_NEG = 3, M_FAULT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scan_en = 1'b0;
    logic       pol_req = 1'b0;
    logic [3:0] amp_code = 4'd0;
    logic       cfg_valid = 1'b0;
    logic       fault_clr = 1'b0;
    logic       HB_AH, HB_AL, HB_BH, HB_BL;
    logic [2:0] drv_state;
    logic       fault;
    logic [7:0] dut_vec;

    int checks = 0;
    int errors = 0;

    // model: mode, latched amp, target polarity, time in DEAD, time in drive
    int m_st, m_amp, m_tgt, m_dead, m_on;
    logic [7:0] e_vec;

    coil_driver #(.DEAD_CYCLES(DEAD), .MAX_ON_CYCLES(MAXON)) dut (
        .CLK_IN(clk), .rst_n(rst_n), .scan_en(scan_en), .pol_req(pol_req),
        .amp_code(amp_code), .cfg_valid(cfg_valid), .fault_clr(fault_clr),
        .HB_AH(HB_AH), .HB_AL(HB_AL), .HB_BH(HB_BH), .HB_BL(HB_BL),
        .drv_state(drv_state), .fault(fault)
    );

    always #5 clk = ~clk;

    assign dut_vec = {HB_AH, HB_AL, HB_BH, HB_BL, drv_state, fault};

    function automatic void model_reset();
        m_st = M_IDLE; m_amp = 0; m_tgt = 0; m_dead = 0; m_on = 0;
        e_vec = 8'h00;
    endfunction

    function automatic void model_step(input logic s, input logic p,
                                       input logic [3:0] a, input logic cv,
                                       input logic fc);
        int nst;
        int old_amp;
        bit drv_now;
        bit pwm;
        old_amp = m_amp;
        nst = m_st;
        if (m_st == M_IDLE && cv) m_amp = int'(a);
        case (m_st)
            M_IDLE: if (s && old_amp != 0) begin nst = M_DEAD; m_tgt = int'(p); end
            M_DEAD: begin
                if (!s) nst = M_IDLE;
                else if (m_dead == DEAD - 1) nst = (m_tgt == 1) ? M_POS : M_NEG;
            end
            M_POS, M_NEG: begin
                if (m_on == MAXON - 1) nst = M_FAULT;
                else if (!s) nst = M_IDLE;
                else if (int'(p) != ((m_st == M_POS) ? 1 : 0)) begin
                    nst = M_DEAD; m_tgt = int'(p);
                end
            end
            M_FAULT: if (fc) nst = M_IDLE;
            default: nst = M_IDLE;
        endcase
        drv_now = (m_st == M_POS) || (m_st == M_NEG);
        m_dead = (nst == M_DEAD && m_st == M_DEAD) ? m_dead + 1 : 0;
        m_on = (drv_now && nst == m_st) ? m_on + 1 : 0;
        m_st = nst;
        pwm = (m_on % 16) < m_amp;
        e_vec = {m_st == M_POS && pwm, m_st == M_NEG, m_st == M_NEG && pwm,
                 m_st == M_POS, 3'(m_st), m_st == M_FAULT};
    endfunction

    task automatic tick(input logic s, input logic p, input logic [3:0] a,
                        input logic cv, input logic fc);
        scan_en = s; pol_req = p; amp_code = a; cfg_valid = cv; fault_clr = fc;
        @(posedge clk);
        model_step(s, p, a, cv, fc);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #3;
        checks++;
        if (dut_vec !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold got %b want %b", dut_vec, 8'h00);
        end
        #10 rst_n = 1'b1;
        tick(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        checks++;
        if (dut_vec !== e_vec) begin
            errors++;
            $display("FAIL reset_amp0_idle got %b want %b", dut_vec, e_vec);
        end
    endtask

    task automatic test_latch_pos();
        int off_cnt;
        int ah_cnt;
        int bl_cnt;
        off_cnt = 0; ah_cnt = 0; bl_cnt = 0;
        tick(1'b0, 1'b1, 4'd8, 1'b1, 1'b0);
        for (int i = 0; i < 12 && m_st != M_POS; i++) begin
            tick(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
            if (m_st != M_POS && {HB_AH, HB_AL, HB_BH, HB_BL} == 4'b0000) off_cnt++;
            checks++;
            if (dut_vec !== e_vec) begin
                errors++;
                $display("FAIL latch_dead got %b want %b", dut_vec, e_vec);
            end
        end
        checks++;
        if (off_cnt != DEAD) begin
            errors++;
            $display("FAIL latch_deadtime got %0d want %0d", off_cnt, DEAD);
        end
        ah_cnt += int'(HB_AH); bl_cnt += int'(HB_BL);
        for (int i = 0; i < 15; i++) begin
            tick(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
            ah_cnt += int'(HB_AH); bl_cnt += int'(HB_BL);
            checks++;
            if (dut_vec !== e_vec) begin
                errors++;
                $display("FAIL latch_pos got %b want %b", dut_vec, e_vec);
            end
        end
        checks++;
        if (ah_cnt != 8 || bl_cnt != 16) begin
            errors++;
            $display("FAIL latch_duty got ah=%0d bl=%0d want ah=8 bl=16", ah_cnt, bl_cnt);
        end
    endtask

    task automatic test_flip();
        int off_cnt;
        int al_cnt;
        int bh_cnt;
        int overlap;
        off_cnt = 0; al_cnt = 0; bh_cnt = 0; overlap = 0;
        for (int i = 0; i < 12 && m_st != M_NEG; i++) begin
            tick(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
            if (m_st != M_NEG && {HB_AH, HB_AL, HB_BH, HB_BL} == 4'b0000) off_cnt++;
            checks++;
            if (dut_vec !== e_vec) begin
                errors++;
                $display("FAIL flip_dead got %b want %b", dut_vec, e_vec);
            end
        end
        checks++;
        if (off_cnt != DEAD || drv_state !== 3'd3) begin
            errors++;
            $display("FAIL flip_deadtime got off=%0d st=%0d want off=%0d st=3",
                     off_cnt, drv_state, DEAD);
        end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
            al_cnt += int'(HB_AL); bh_cnt += int'(HB_BH);
            if ((HB_AH && HB_AL) || (HB_BH && HB_BL)) overlap++;
            checks++;
            if (dut_vec !== e_vec) begin
                errors++;
                $display("FAIL flip_neg got %b want %b", dut_vec, e_vec);
            end
        end
        checks++;
        if (al_cnt != 16 || bh_cnt != 8 || overlap != 0) begin
            errors++;
            $display("FAIL flip_duty got al=%0d bh=%0d ovl=%0d want al=16 bh=8 ovl=0",
                     al_cnt, bh_cnt, overlap);
        end
    endtask

    task automatic measure_pos(input string tag, input int want,
                               input logic cv_first, input logic [3:0] a_first);
        int ah_cnt;
        ah_cnt = 0;
        for (int i = 0; i < 12 && m_st != M_POS; i++) begin
            tick(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
            checks++;
            if (dut_vec !== e_vec) begin
                errors++;
                $display("FAIL %s_enter got %b want %b", tag, dut_vec, e_vec);
            end
        end
        ah_cnt += int'(HB_AH);
        for (int i = 0; i < 15; i++) begin
            tick(1'b1, 1'b1, a_first, (i == 0) ? cv_first : 1'b0, 1'b0);
            ah_cnt += int'(HB_AH);
            checks++;
            if (dut_vec !== e_vec) begin
                errors++;
                $display("FAIL %s_pos got %b want %b", tag, dut_vec, e_vec);
            end
        end
        checks++;
        if (ah_cnt != want) begin
            errors++;
            $display("FAIL %s_duty got %0d/16 want %0d/16", tag, ah_cnt, want);
        end
    endtask

    task automatic test_lockout();
        measure_pos("lock", 8, 1'b1, 4'd3);
        tick(1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
        measure_pos("relatch", 3, 1'b0, 4'd0);
    endtask

    task automatic test_amp_edges();
        tick(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b1, 4'd9, 1'b0, 1'b0);
            checks++;
            if (dut_vec !== e_vec || dut_vec !== 8'h00) begin
                errors++;
                $display("FAIL amp0_idle got %b want %b", dut_vec, e_vec);
            end
        end
        tick(1'b0, 1'b1, 4'd15, 1'b1, 1'b0);
        measure_pos("amp15", 15, 1'b0, 4'd0);
    endtask

    task automatic test_watchdog();
        int pos_cnt;
        pos_cnt = 0;
        tick(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 100 && fault !== 1'b1; i++) begin
            tick(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
            if (drv_state == 3'd2) pos_cnt++;
            checks++;
            if (dut_vec !== e_vec) begin
                errors++;
                $display("FAIL wdog_run got %b want %b", dut_vec, e_vec);
            end
        end
        checks++;
        if (pos_cnt != MAXON || dut_vec !== 8'b0000_100_1) begin
            errors++;
            $display("FAIL wdog_trip got pos=%0d vec=%b want pos=%0d vec=00001001",
                     pos_cnt, dut_vec, MAXON);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'(i % 2), 1'b0, 4'd5, 1'b1, 1'b0);
            checks++;
            if (dut_vec !== e_vec || fault !== 1'b1) begin
                errors++;
                $display("FAIL wdog_hold got %b want %b", dut_vec, e_vec);
            end
        end
        tick(1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        checks++;
        if (dut_vec !== e_vec || dut_vec !== 8'h00) begin
            errors++;
            $display("FAIL wdog_clear got %b want %b", dut_vec, e_vec);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 12 && m_st != M_NEG; i++) begin
            tick(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        end
        tick(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (dut_vec !== e_vec || HB_AL !== 1'b1) begin
            errors++;
            $display("FAIL areset_neg got %b want %b", dut_vec, e_vec);
        end
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_vec !== 8'h00) begin
            errors++;
            $display("FAIL areset_drop got %b want %b", dut_vec, 8'h00);
        end
        #20 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 4'd7, 1'b0, 1'b0);
            checks++;
            if (dut_vec !== e_vec || dut_vec !== 8'h00) begin
                errors++;
                $display("FAIL areset_after got %b want %b", dut_vec, e_vec);
            end
        end
    endtask

    task automatic test_random();
        logic s, p, cv, fc;
        logic [3:0] a;
        int off_run;
        off_run = 100;
        p = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 29) == 0) p = ~p;
            a = 4'($urandom_range(0, 15));
            cv = ($urandom_range(0, 7) == 0);
            fc = ($urandom_range(0, 11) == 0);
            tick(s, p, a, cv, fc);
            checks++;
            if (dut_vec !== e_vec) begin
                errors++;
                $display("FAIL rand_cycle i=%0d got %b want %b", i, dut_vec, e_vec);
            end
            if ({HB_AH, HB_AL, HB_BH, HB_BL} == 4'b0000) begin
                off_run++;
            end else begin
                checks++;
                if ((HB_AH && HB_AL) || (HB_BH && HB_BL) || off_run == 0 ? 1'b0 : off_run < DEAD) begin
                    errors++;
                    $display("FAIL rand_safety i=%0d gates=%b offrun=%0d",
                             i, {HB_AH, HB_AL, HB_BH, HB_BL}, off_run);
                end
                off_run = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_latch_pos();
        test_flip();
        test_lockout();
        test_amp_edges();
        test_watchdog();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
